mf_disp_scan: RTL and testbench

- Display scan engine and read-side master of the frame buffer/palette pair.
- Generates raster timing (hsync/vsync/data-enable) and issues pix_rd_vld/pix_rd_addr for every active pixel.
- Re-aligns the returned palette RGB with delayed sync/DE and drives the panel.
- Owns fb_active_sel and performs CPU-requested double-buffer swaps only during vertical sync.

---
 rtl/mf_disp_scan_pkg.sv | 27 ++
 rtl/mf_disp_dly_line.sv | 27 ++
 rtl/mf_disp_scan.sv | 179 +++++++++++++++++
 tb/tb_mf_disp_scan.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mf_disp_scan_pkg.sv
// mf_disp_scan_pkg: default raster timing, read latency, sync polarity encoding and region helpers
package mf_disp_scan_pkg;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 192;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 21;
    localparam int DEF_RD_LAT   = 3;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    // Length of a full line or frame: active + front porch + sync + back porch
    function automatic int region_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // First count of the sync pulse: sync follows active and front porch
    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

endpackage

// File: rtl/mf_disp_dly_line.sv
// mf_disp_dly_line: WIDTH-bit shift register of DEPTH stages with async reset to RST_VAL
module mf_disp_dly_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the input through DEPTH stages; reset loads the idle value so nothing spurious emerges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mf_disp_scan.sv
// mf_disp_scan: raster scan engine, frame-buffer read master and vsync-time buffer swapper (option MF_DISP_SCAN_DOUBLE_EN: 2x2 pixel doubling)
module mf_disp_scan
    import mf_disp_scan_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = SYNC_ACT_LOW,
    parameter int   RD_LAT   = DEF_RD_LAT
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        fb_swap_req,
    output logic        fb_swap_ack,
    output logic        fb_active_sel,
    output logic        pix_rd_vld,
    output logic [15:0] pix_rd_addr,
    input  logic [5:0]  pix_rd_rdata,
    input  logic [5:0]  pix_rd_gdata,
    input  logic [5:0]  pix_rd_bdata,
    output logic        disp_hsync,
    output logic        disp_vsync,
    output logic        disp_de,
    output logic [5:0]  disp_r,
    output logic [5:0]  disp_g,
    output logic [5:0]  disp_b,
    output logic        frame_start
);

    localparam int H_TOTAL = region_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = region_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SS    = sync_start(H_ACTIVE, H_FP);
    localparam int V_SS    = sync_start(V_ACTIVE, V_FP);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C    = HW'(H_SS);
    localparam logic [HW-1:0] H_SE_C    = HW'(H_SS + H_SYNC);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C    = VW'(V_SS);
    localparam logic [VW-1:0] V_SE_C    = VW'(V_SS + V_SYNC);

    if (H_ACTIVE * V_ACTIVE > 65536) begin : g_size_chk
        $error("mf_disp_scan: active area exceeds the 16-bit pixel address space");
    end
    if (RD_LAT < 2) begin : g_lat_chk
        $error("mf_disp_scan: RD_LAT must be at least 2");
    end

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_pend;
    logic [2:0]    r_raw;
    logic          w_h_wrap, w_active, w_hs, w_vs, w_frame, w_do_swap;
    logic [2:0]    w_dly;

    assign w_h_wrap    = r_h == H_LAST_C;
    assign w_active    = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hs        = (r_h >= H_SS_C) && (r_h < H_SE_C);
    assign w_vs        = (r_v >= V_SS_C) && (r_v < V_SE_C);
    assign w_frame     = (r_h == '0) && (r_v == '0);
    assign w_do_swap   = r_pend && (r_h == '0) && (r_v == V_SS_C);
    assign frame_start = rst_n & w_frame;

    // Raster position: h runs over a full line, v advances on each line wrap
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : r_h + HW'(1);
            if (w_h_wrap) r_v <= (r_v == V_LAST_C) ? '0 : r_v + VW'(1);
        end
    end

    // Read strobe and raw timing are captured together so they share one pipeline origin
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rd_vld <= 1'b0;
            r_raw      <= {1'b0, ~SYNC_POL, ~SYNC_POL};
        end else begin
            pix_rd_vld <= w_active;
            r_raw      <= {w_active, w_hs ? SYNC_POL : ~SYNC_POL, w_vs ? SYNC_POL : ~SYNC_POL};
        end
    end

`ifdef MF_DISP_SCAN_DOUBLE_EN
    logic        r_col_odd, r_col_last, r_row_odd;
    logic [15:0] r_line_base;
    logic [15:0] w_addr_inc;

    assign w_addr_inc = pix_rd_addr + 16'd1;

    // Column/row parity of the pixel being read, aligned with pix_rd_vld
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_odd  <= 1'b0;
            r_col_last <= 1'b0;
            r_row_odd  <= 1'b0;
        end else begin
            r_col_odd  <= r_h[0];
            r_col_last <= r_h == H_ACT_C - HW'(1);
            r_row_odd  <= r_v[0];
        end
    end

    // Each source pixel covers two columns; even lines rewind to line_base so odd lines repeat them
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rd_addr <= '0;
            r_line_base <= '0;
        end else if (w_frame) begin
            pix_rd_addr <= '0;
            r_line_base <= '0;
        end else if (pix_rd_vld) begin
            if (r_col_last && !r_row_odd) pix_rd_addr <= r_line_base;
            else if (r_col_odd) pix_rd_addr <= w_addr_inc;
            if (r_col_last && r_row_odd) r_line_base <= w_addr_inc;
        end
    end
`else
    // Linear address: cleared at frame start, one step per pixel read, wraps at 2^16
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) pix_rd_addr <= '0;
        else if (w_frame) pix_rd_addr <= '0;
        else if (pix_rd_vld) pix_rd_addr <= pix_rd_addr + 16'd1;
    end
`endif

    mf_disp_dly_line #(
        .WIDTH   (3),
        .DEPTH   (RD_LAT - 1),
        .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
    ) u_dly (
        .i_clk   (pix_clk),
        .i_rst_n (rst_n),
        .i_d     (r_raw),
        .o_q     (w_dly)
    );

    // Final stage registers timing and palette data together so RGB lines up with disp_de
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_de    <= 1'b0;
            disp_hsync <= ~SYNC_POL;
            disp_vsync <= ~SYNC_POL;
            disp_r     <= '0;
            disp_g     <= '0;
            disp_b     <= '0;
        end else begin
            {disp_de, disp_hsync, disp_vsync} <= w_dly;
            disp_r <= w_dly[2] ? pix_rd_rdata : '0;
            disp_g <= w_dly[2] ? pix_rd_gdata : '0;
            disp_b <= w_dly[2] ? pix_rd_bdata : '0;
        end
    end

    // Requests collapse into one pending flag that is consumed on the first vsync line
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= 1'b0;
            fb_active_sel <= 1'b0;
            fb_swap_ack   <= 1'b0;
        end else begin
            r_pend        <= (r_pend & ~w_do_swap) | fb_swap_req;
            fb_active_sel <= fb_active_sel ^ w_do_swap;
            fb_swap_ack   <= w_do_swap;
        end
    end

endmodule

// File: tb/tb_mf_disp_scan.sv
// tb_mf_disp_scan: randomized swap requests and raster checks for mf_disp_scan against an arithmetic raster model
module tb_mf_disp_scan;

    localparam int   HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int   VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int   RD_LAT = 3;
    localparam logic POL = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;

    logic        pix_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fb_swap_req = 1'b0;
    logic        fb_swap_ack, fb_active_sel, pix_rd_vld;
    logic [15:0] pix_rd_addr;
    logic [5:0]  pix_rd_rdata, pix_rd_gdata, pix_rd_bdata;
    logic        disp_hsync, disp_vsync, disp_de, frame_start;
    logic [5:0]  disp_r, disp_g, disp_b;

    mf_disp_scan #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .RD_LAT (RD_LAT)
    ) dut (
        .pix_clk       (pix_clk),
        .rst_n         (rst_n),
        .fb_swap_req   (fb_swap_req),
        .fb_swap_ack   (fb_swap_ack),
        .fb_active_sel (fb_active_sel),
        .pix_rd_vld    (pix_rd_vld),
        .pix_rd_addr   (pix_rd_addr),
        .pix_rd_rdata  (pix_rd_rdata),
        .pix_rd_gdata  (pix_rd_gdata),
        .pix_rd_bdata  (pix_rd_bdata),
        .disp_hsync    (disp_hsync),
        .disp_vsync    (disp_vsync),
        .disp_de       (disp_de),
        .disp_r        (disp_r),
        .disp_g        (disp_g),
        .disp_b        (disp_b),
        .frame_start   (frame_start)
    );

    always #5 pix_clk = ~pix_clk;

    // Palette stand-in: colour derived from the requested address, returned after the read latency
    logic [15:0] pal [RD_LAT-1];
    always @(posedge pix_clk) begin
        pal[0] <= pix_rd_addr;
        for (int i = 1; i < RD_LAT - 1; i++) pal[i] <= pal[i-1];
    end
    assign pix_rd_rdata = pal[RD_LAT-2][5:0];
    assign pix_rd_gdata = pal[RD_LAT-2][11:6];
    assign pix_rd_bdata = pal[RD_LAT-2][5:0] ^ 6'h2a;

    int          vectors = 0, errors = 0;
    logic [17:0] sb_q [$];
    int          t, last_req, prev_pt, mode;
    logic        exp_sel, exp_ack;

    function automatic int hpos(input int c); return c % HT; endfunction
    function automatic int vpos(input int c); return (c / HT) % VT; endfunction
    function automatic logic is_act(input int c); return hpos(c) < HA && vpos(c) < VA; endfunction
    function automatic logic in_hs(input int c); return hpos(c) >= HA + HF && hpos(c) < HA + HF + HS; endfunction
    function automatic logic in_vs(input int c); return vpos(c) >= VA + VF && vpos(c) < VA + VF + VS; endfunction

    function automatic int pidx(input int c);
`ifdef MF_DISP_SCAN_DOUBLE_EN
        return (vpos(c) / 2) * (HA / 2) + hpos(c) / 2;
`else
        return vpos(c) * HA + hpos(c);
`endif
    endfunction

    function automatic logic [17:0] rgb(input int idx);
        logic [15:0] a;
        a = 16'(idx);
        return {a[5:0], a[11:6], a[5:0] ^ 6'h2a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h want %0h", name, t, act, exp);
        end
    endtask

    // Monitor: every displayed pixel pops the next expected colour from the scoreboard
    always @(posedge pix_clk) begin
        #1;
        if (rst_n && disp_de) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rgb t=%0d got %0h want <empty scoreboard>", t, {disp_r, disp_g, disp_b});
            end else begin
                logic [17:0] e;
                e = sb_q.pop_front();
                chk("rgb", {14'd0, disp_r, disp_g, disp_b}, {14'd0, e});
            end
        end
    end

    // One raster cycle: check outputs for cycle t, advance the model, drive the next request
    task automatic step();
        int d;
        logic rq;
        @(negedge pix_clk);
        d = t - 1 - RD_LAT;
        chk("frame_start", frame_start, hpos(t) == 0 && vpos(t) == 0);
        chk("rd_vld", pix_rd_vld, t >= 1 && is_act(t - 1));
        if (t >= 1 && is_act(t - 1)) chk("rd_addr", pix_rd_addr, pidx(t - 1) & 16'hffff);
        chk("de", disp_de, d >= 0 && is_act(d));
        chk("hsync", disp_hsync, (d >= 0 && in_hs(d)) ? POL : !POL);
        chk("vsync", disp_vsync, (d >= 0 && in_vs(d)) ? POL : !POL);
        if (!(d >= 0 && is_act(d))) chk("rgb_blank", {disp_r, disp_g, disp_b}, 0);
        chk("sel", fb_active_sel, exp_sel);
        chk("ack", fb_swap_ack, exp_ack);
        exp_ack = 1'b0;
        if (hpos(t) == 0 && vpos(t) == VA + VF) begin
            if (last_req >= prev_pt) begin
                exp_sel = !exp_sel;
                exp_ack = 1'b1;
            end
            prev_pt = t;
        end
        if (is_act(t)) sb_q.push_back(rgb(pidx(t)));
        rq = mode == 0 ? ($urandom_range(0, 119) == 0) :
             mode == 1 ? (hpos(t) == 0 && vpos(t) == VA + VF) : 1'b0;
        fb_swap_req = rq;
        if (rq) last_req = t;
        t++;
    endtask

    task automatic model_reset();
        t = 0;
        last_req = -1;
        prev_pt = 0;
        exp_sel = 1'b0;
        exp_ack = 1'b0;
        sb_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"}, pix_rd_vld, 0);
        chk({tag, "_addr"}, pix_rd_addr, 0);
        chk({tag, "_de"}, disp_de, 0);
        chk({tag, "_hsync"}, disp_hsync, !POL);
        chk({tag, "_vsync"}, disp_vsync, !POL);
        chk({tag, "_rgb"}, {disp_r, disp_g, disp_b}, 0);
        chk({tag, "_sel"}, fb_active_sel, 0);
        chk({tag, "_ack"}, fb_swap_ack, 0);
        chk({tag, "_fs"}, frame_start, 0);
    endtask

    initial begin
        model_reset();
        mode = 0;
        repeat (3) @(negedge pix_clk);
        chk_reset_vals("por");
        @(posedge pix_clk);
        #1 rst_n = 1'b1;
        repeat (4 * HT * VT) step();
        mode = 2;
        repeat (HT * VT + HT * VT / 2) step();
        mode = 1;
        repeat (3 * HT * VT) step();
        mode = 0;
        while (!(hpos(t) == 7 && vpos(t) == 5)) step();
        #2 rst_n = 1'b0;
        fb_swap_req = 1'b0;
        #1 chk_reset_vals("midrst");
        model_reset();
        repeat (3) @(negedge pix_clk);
        @(posedge pix_clk);
        #1 rst_n = 1'b1;
        repeat (3 * HT * VT) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
